shift_seq_ctrl: RTL and testbench

SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

---
 rtl/shift_seq_ctrl.sv | 135 +++++++++++++
 tb/tb_shift_seq_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq_ctrl.sv
// Frame serializer: shifts a captured parallel frame out LSB-first while capturing
// the serial return bits, then inserts a programmable idle gap before the next frame.
module shift_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int GAP   = 2,
  localparam int LW   = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LW-1:0]    in_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             abort,
  input  logic             sin,
  output logic             sout,
  output logic             shift_en,
  output logic             busy,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  localparam logic [LW-1:0] WLEN     = LW'(WIDTH);
  localparam logic [3:0]    GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_t           state, next_state;
  logic [WIDTH-1:0] data_sr;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] rx_next;
  logic [LW-1:0]    len_q;
  logic [LW-1:0]    cnt;
  logic [LW-1:0]    eff_len;
  logic [3:0]       gcnt;
  logic             accept;
  logic             last;

  assign in_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    last       = (cnt == len_q - LW'(1));
    eff_len    = ((in_len == '0) || (in_len > WLEN)) ? WLEN : in_len;
    // Return bit of the current shift cycle merged so the final bit reaches rx_data.
    rx_next    = shadow | (WIDTH'(sin) << cnt);
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          accept     = 1'b1;
          next_state = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (abort)     next_state = S_IDLE;
        else if (last) next_state = (GAP > 0) ? S_GAP : S_IDLE;
      end
      S_GAP: begin
        if (gcnt == GAP_LAST) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_sr  <= '0;
      shadow   <= '0;
      len_q    <= '0;
      cnt      <= '0;
      gcnt     <= '0;
      sout     <= 1'b0;
      shift_en <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          sout     <= 1'b0;
          shift_en <= 1'b0;
          if (accept) begin
            // Bit 0 goes straight to sout so it appears in the first cycle after accept.
            data_sr  <= in_data >> 1;
            len_q    <= eff_len;
            cnt      <= '0;
            shadow   <= '0;
            sout     <= in_data[0];
            shift_en <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (abort) begin
            sout     <= 1'b0;
            shift_en <= 1'b0;
          end else if (last) begin
            rx_data  <= rx_next;
            shadow   <= rx_next;
            rx_valid <= 1'b1;
            done     <= 1'b1;
            sout     <= 1'b0;
            shift_en <= 1'b0;
            gcnt     <= '0;
          end else begin
            shadow   <= rx_next;
            cnt      <= cnt + LW'(1);
            sout     <= data_sr[0];
            data_sr  <= data_sr >> 1;
            shift_en <= 1'b1;
          end
        end
        S_GAP: begin
          sout     <= 1'b0;
          shift_en <= 1'b0;
          gcnt     <= gcnt + 4'd1;
        end
        default: begin
          sout     <= 1'b0;
          shift_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl: one instance with a 2-cycle gap, one with no gap.
module tb_shift_seq_ctrl;

  logic       clk;
  logic       rst;

  logic [7:0] in_data;
  logic [3:0] in_len;
  logic       in_valid, in_ready, abort, sin, sout, shift_en, busy, rx_valid, done;
  logic [7:0] rx_data;
  logic       loop, sin_val;

  logic [7:0] in_data_b;
  logic [3:0] in_len_b;
  logic       in_valid_b, in_ready_b, abort_b, sin_b, sout_b, shift_en_b, busy_b, rx_valid_b, done_b;
  logic [7:0] rx_data_b;

  int total;
  int bad;

  assign sin   = loop ? sout : sin_val;
  assign sin_b = sout_b;

  shift_seq_ctrl #(.WIDTH(8), .GAP(2)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_len(in_len), .in_valid(in_valid),
    .in_ready(in_ready), .abort(abort), .sin(sin), .sout(sout), .shift_en(shift_en),
    .busy(busy), .rx_data(rx_data), .rx_valid(rx_valid), .done(done)
  );

  shift_seq_ctrl #(.WIDTH(8), .GAP(0)) dut_b (
    .clk(clk), .rst(rst), .in_data(in_data_b), .in_len(in_len_b), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .abort(abort_b), .sin(sin_b), .sout(sout_b), .shift_en(shift_en_b),
    .busy(busy_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b), .done(done_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("idle_wait", 32'(in_ready), 32'd1);
  endtask

  task automatic run_frame(input logic [7:0] d, input logic [3:0] len, input logic lp,
                           input logic sv, input logic ab, input int exp_n,
                           input logic [7:0] exp_rx);
    int n;
    n = 0;
    wait_idle();
    in_data  = d;
    in_len   = len;
    in_valid = 1'b1;
    abort    = ab;
    loop     = lp;
    sin_val  = sv;
    tick();
    in_valid = 1'b0;
    abort    = 1'b0;
    while (shift_en && n < 40) begin
      if (n < 8) chk("sout_bit", 32'(sout), 32'(d[n[2:0]]));
      chk("busy_shift", 32'(busy), 32'd1);
      n++;
      tick();
    end
    chk("n_shift", 32'(n), 32'(exp_n));
    chk("done", 32'(done), 32'd1);
    chk("rx_valid", 32'(rx_valid), 32'd1);
    chk("rx_data", 32'(rx_data), 32'(exp_rx));
  endtask

  initial begin
    int ns, nd;
    logic [31:0] pat;
    total      = 0;
    bad        = 0;
    rst        = 1'b1;
    in_data    = '0;
    in_len     = '0;
    in_valid   = 1'b0;
    abort      = 1'b0;
    loop       = 1'b1;
    sin_val    = 1'b0;
    in_data_b  = '0;
    in_len_b   = '0;
    in_valid_b = 1'b0;
    abort_b    = 1'b0;
    tick();
    tick();
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_shift_en", 32'(shift_en), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();

    // 0xA5 loopback, then gap timing: in_ready back 3 cycles after last shift cycle
    run_frame(8'hA5, 4'd8, 1'b1, 1'b0, 1'b0, 8, 8'hA5);
    chk("gap_ready0", 32'(in_ready), 32'd0);
    tick();
    chk("done_pulse", 32'(done), 32'd0);
    chk("gap_ready1", 32'(in_ready), 32'd0);
    tick();
    chk("gap_ready2", 32'(in_ready), 32'd1);

    // abort on shift cycle 4 of 0x3C
    wait_idle();
    in_data  = 8'h3C;
    in_len   = 4'd8;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("abort_pre_se", 32'(shift_en), 32'd1);
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_se", 32'(shift_en), 32'd0);
    chk("abort_sout", 32'(sout), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_rxv", 32'(rx_valid), 32'd0);
    chk("abort_rx", 32'(rx_data), 32'hA5);
    chk("abort_ready", 32'(in_ready), 32'd1);

    run_frame(8'hFF, 4'd3, 1'b0, 1'b1, 1'b0, 3, 8'h07);
    run_frame(8'h5A, 4'd0, 1'b1, 1'b0, 1'b0, 8, 8'h5A);
    run_frame(8'hC3, 4'd12, 1'b1, 1'b0, 1'b0, 8, 8'hC3);
    // abort together with in_valid in IDLE must not block acceptance
    run_frame(8'h96, 4'd8, 1'b1, 1'b0, 1'b1, 8, 8'h96);

    // abort on the final shift cycle beats completion
    wait_idle();
    in_data  = 8'h3C;
    in_len   = 4'd8;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("last_se", 32'(shift_en), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("alast_done", 32'(done), 32'd0);
    chk("alast_rxv", 32'(rx_valid), 32'd0);
    chk("alast_se", 32'(shift_en), 32'd0);
    chk("alast_rx", 32'(rx_data), 32'h96);
    chk("alast_ready", 32'(in_ready), 32'd1);
    tick();
    chk("alast_done2", 32'(done), 32'd0);

    // reset mid-frame
    in_data  = 8'hE7;
    in_len   = 4'd8;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_sout", 32'(sout), 32'd0);
    chk("mrst_se", 32'(shift_en), 32'd0);
    chk("mrst_rx", 32'(rx_data), 32'd0);
    chk("mrst_rxv", 32'(rx_valid), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_ready", 32'(in_ready), 32'd1);
    tick();
    chk("mrst_done2", 32'(done), 32'd0);

    // GAP=0: back-to-back frames with in_valid held high
    in_data_b  = 8'h01;
    in_len_b   = 4'd8;
    in_valid_b = 1'b1;
    tick();
    in_data_b = 8'h80;
    ns  = 0;
    nd  = 0;
    pat = '0;
    for (int c = 1; c <= 20; c++) begin
      if (shift_en_b) begin
        ns++;
        pat[c] = 1'b1;
      end
      if (done_b) nd++;
      if (c == 1)  chk("b_sout_c1", 32'(sout_b), 32'd1);
      if (c == 8)  chk("b_sout_c8", 32'(sout_b), 32'd0);
      if (c == 9)  chk("b_done_c9", 32'(done_b), 32'd1);
      if (c == 9)  chk("b_rx1", 32'(rx_data_b), 32'h01);
      if (c == 17) chk("b_sout_c17", 32'(sout_b), 32'd1);
      if (c == 18) chk("b_done_c18", 32'(done_b), 32'd1);
      if (c == 10) in_valid_b = 1'b0;
      tick();
    end
    chk("b_pattern", pat, 32'h0003FDFE);
    chk("b_nshift", 32'(ns), 32'd16);
    chk("b_ndone", 32'(nd), 32'd2);
    chk("b_rx2", 32'(rx_data_b), 32'h80);
    chk("b_ready", 32'(in_ready_b), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
